// File: rtl/pipeline_pkg.sv
// Shared types for the ready/valid pipeline stages: the stage state encoding
// and the default stall-counter width.
package pipeline_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        EMPTY = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int COUNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/register_clear_n.sv
// Enable register with asynchronous active-low clear to a parameterised value.
module register_clear_n #(
    parameter int                    WORD_WIDTH  = 1,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  enable,
    input  logic [WORD_WIDTH-1:0] next_value,
    output logic [WORD_WIDTH-1:0] value
);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            value <= RESET_VALUE;
        end else if (enable) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/pipeline_reverse_register.sv
// Single-entry stage that registers the ready path and passes valid/data through
// while empty. Optional saturating stall counter under PIPELINE_REVERSE_REGISTER_STALL_COUNT_EN.
//
// state | meaning
// INIT  | one-cycle wake-up after clear_n release, nothing accepted or offered
// EMPTY | pass-through, input_ready high
// FULL  | buffer holds one word, input side blocked
module pipeline_reverse_register
    import pipeline_pkg::*;
#(
    parameter int WORD_WIDTH = 0,
`ifdef PIPELINE_REVERSE_REGISTER_STALL_COUNT_EN
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
`endif
    // WORD_WIDTH must be set >= 1; the clamp only keeps an unset default elaborable.
    localparam int DW = (WORD_WIDTH > 0) ? WORD_WIDTH : 1
) (
    input  logic          clock,
    input  logic          clear_n,
    input  logic          input_valid,
    output logic          input_ready,
    input  logic [DW-1:0] input_data,
    output logic          output_valid,
    input  logic          output_ready,
    output logic [DW-1:0] output_data
`ifdef PIPELINE_REVERSE_REGISTER_STALL_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] stall_count
`endif
);

    state_t        state;
    state_t        state_next;
    logic          ready_q;
    logic          buffer_load;
    logic [DW-1:0] buffer;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= INIT;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == EMPTY);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    state_next = EMPTY;
            EMPTY:   if (input_valid && !output_ready) state_next = FULL;
            FULL:    if (output_ready) state_next = EMPTY;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        output_valid = 1'b0;
        output_data  = buffer;
        case (state)
            EMPTY: begin
                output_valid = input_valid;
                output_data  = input_data;
            end
            FULL: begin
                output_valid = 1'b1;
                output_data  = buffer;
            end
            default: begin
                output_valid = 1'b0;
                output_data  = buffer;
            end
        endcase
    end

    // input_ready is the flop itself, so output_ready never reaches it combinationally.
    assign input_ready = ready_q;

    assign buffer_load = (state == EMPTY) && input_valid && !output_ready;

    register_clear_n #(
        .WORD_WIDTH  (DW),
        .RESET_VALUE ('0)
    ) u_buffer (
        .clock      (clock),
        .clear_n    (clear_n),
        .enable     (buffer_load),
        .next_value (input_data),
        .value      (buffer)
    );

`ifdef PIPELINE_REVERSE_REGISTER_STALL_COUNT_EN
    logic stall_inc;

    assign stall_inc = (state == FULL) && !output_ready && (stall_count != '1);

    register_clear_n #(
        .WORD_WIDTH  (COUNT_WIDTH),
        .RESET_VALUE ('0)
    ) u_stall_count (
        .clock      (clock),
        .clear_n    (clear_n),
        .enable     (stall_inc),
        .next_value (stall_count + COUNT_WIDTH'(1)),
        .value      (stall_count)
    );
`endif

endmodule

// File: tb/tb_pipeline_reverse_register.sv
// Directed self-checking bench for pipeline_reverse_register (8-bit words;
// counter checks when PIPELINE_REVERSE_REGISTER_STALL_COUNT_EN is defined).
module tb_pipeline_reverse_register;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       input_valid;
    logic       input_ready;
    logic [7:0] input_data;
    logic       output_valid;
    logic       output_ready;
    logic [7:0] output_data;
`ifdef PIPELINE_REVERSE_REGISTER_STALL_COUNT_EN
    logic [3:0] stall_count;
`endif

    int passed = 0;
    int total  = 0;

    pipeline_reverse_register #(
        .WORD_WIDTH (8)
`ifdef PIPELINE_REVERSE_REGISTER_STALL_COUNT_EN
        ,
        .COUNT_WIDTH (4)
`endif
    ) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
`ifdef PIPELINE_REVERSE_REGISTER_STALL_COUNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_n      = 1'b0;
        input_valid  = 1'b0;
        input_data   = 8'h00;
        output_ready = 1'b0;
        #2;
        total++; if (input_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", input_ready); else passed++;
        total++; if (output_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", output_valid); else passed++;
        total++; if (output_data !== 8'h00) $display("FAIL reset_data got %h want 00", output_data); else passed++;
        tick();
        clear_n = 1'b1;
        #1;
        total++; if (input_ready !== 1'b0) $display("FAIL init_ready got %b want 0", input_ready); else passed++;
        tick();
        total++; if (input_ready !== 1'b1) $display("FAIL wake_ready got %b want 1", input_ready); else passed++;
    endtask

    task automatic test_streaming();
        logic [7:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        output_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            input_valid = 1'b1;
            input_data  = words[i];
            #1;
            total++; if (output_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", i, output_valid); else passed++;
            total++; if (output_data !== words[i]) $display("FAIL stream_data[%0d] got %h want %h", i, output_data, words[i]); else passed++;
            total++; if (input_ready !== 1'b1) $display("FAIL stream_ready[%0d] got %b want 1", i, input_ready); else passed++;
            tick();
        end
        input_valid = 1'b0;
    endtask

    task automatic test_stall();
        output_ready = 1'b0;
        input_valid  = 1'b1;
        input_data   = 8'hA5;
        #1;
        total++; if (output_data !== 8'hA5) $display("FAIL stall_pass got %h want a5", output_data); else passed++;
        tick();
        input_data = 8'h5A;
        #1;
        total++; if (input_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", input_ready); else passed++;
        total++; if (output_valid !== 1'b1) $display("FAIL stall_valid got %b want 1", output_valid); else passed++;
        total++; if (output_data !== 8'hA5) $display("FAIL stall_data got %h want a5", output_data); else passed++;
        output_ready = 1'b1;
        #1;
        total++; if (output_data !== 8'hA5) $display("FAIL release_data got %h want a5", output_data); else passed++;
        tick();
        total++; if (input_ready !== 1'b1) $display("FAIL bubble_ready got %b want 1", input_ready); else passed++;
        total++; if (output_valid !== 1'b1) $display("FAIL resume_valid got %b want 1", output_valid); else passed++;
        total++; if (output_data !== 8'h5A) $display("FAIL resume_data got %h want 5a", output_data); else passed++;
        tick();
        input_valid = 1'b0;
    endtask

    task automatic test_ignore_full();
        output_ready = 1'b0;
        input_valid  = 1'b1;
        input_data   = 8'h77;
        tick();
        for (int i = 0; i < 4; i++) begin
            input_valid = i[0];
            input_data  = i[0] ? 8'hFF : 8'h00;
            #1;
            total++; if (output_data !== 8'h77) $display("FAIL full_data[%0d] got %h want 77", i, output_data); else passed++;
            total++; if (input_ready !== 1'b0) $display("FAIL full_ready[%0d] got %b want 0", i, input_ready); else passed++;
            tick();
        end
        input_valid  = 1'b0;
        output_ready = 1'b1;
        #1;
        total++; if (output_data !== 8'h77) $display("FAIL drain_data got %h want 77", output_data); else passed++;
        tick();
        total++; if (output_valid !== 1'b0) $display("FAIL no_dup_valid got %b want 0", output_valid); else passed++;
        tick();
        total++; if (output_valid !== 1'b0) $display("FAIL no_dup_valid2 got %b want 0", output_valid); else passed++;
    endtask

    task automatic test_reset_full();
        output_ready = 1'b0;
        input_valid  = 1'b1;
        input_data   = 8'h3C;
        tick();
        input_valid = 1'b0;
        input_data  = 8'h00;
        #1;
        total++; if (output_data !== 8'h3C) $display("FAIL held_data got %h want 3c", output_data); else passed++;
        clear_n = 1'b0;
        #1;
        total++; if (output_data !== 8'h00) $display("FAIL rst_full_data got %h want 00", output_data); else passed++;
        total++; if (output_valid !== 1'b0) $display("FAIL rst_full_valid got %b want 0", output_valid); else passed++;
        total++; if (input_ready !== 1'b0) $display("FAIL rst_full_ready got %b want 0", input_ready); else passed++;
        tick();
        clear_n      = 1'b1;
        output_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (output_valid !== 1'b0) $display("FAIL ghost_valid[%0d] got %b want 0", i, output_valid); else passed++;
            tick();
        end
    endtask

`ifdef PIPELINE_REVERSE_REGISTER_STALL_COUNT_EN
    task automatic test_counter();
        total++; if (stall_count !== 4'd0) $display("FAIL cnt_start got %0d want 0", stall_count); else passed++;
        output_ready = 1'b0;
        input_valid  = 1'b1;
        input_data   = 8'h42;
        tick();
        input_valid = 1'b0;
        total++; if (stall_count !== 4'd0) $display("FAIL cnt_capture got %0d want 0", stall_count); else passed++;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 3 || i == 15 || i == 16 || i == 20) begin
                total++;
                if (stall_count !== ((i > 15) ? 4'd15 : 4'(i)))
                    $display("FAIL cnt_after_%0d got %0d want %0d", i, stall_count, (i > 15) ? 15 : i);
                else passed++;
            end
        end
        output_ready = 1'b1;
        tick();
        tick();
        total++; if (stall_count !== 4'd15) $display("FAIL cnt_hold got %0d want 15", stall_count); else passed++;
        clear_n = 1'b0;
        #1;
        total++; if (stall_count !== 4'd0) $display("FAIL cnt_clear got %0d want 0", stall_count); else passed++;
        tick();
        clear_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_ignore_full();
        test_reset_full();
`ifdef PIPELINE_REVERSE_REGISTER_STALL_COUNT_EN
        test_counter();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
